// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they execute as MULTU/DIVU.
module muldiv_hilo_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   localparam logic [5:0] FnMthi  = 6'b010001;
   localparam logic [5:0] FnMtlo  = 6'b010011;
   localparam logic [5:0] FnMult  = 6'b011000;
   localparam logic [5:0] FnMultu = 6'b011001;
   localparam logic [5:0] FnDiv   = 6'b011010;
   localparam logic [5:0] FnDivu  = 6'b011011;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]    cnt_q, cnt_d;
   // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               is_mul_fn, is_div_fn, launch;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign is_mul_fn = (funct == FnMult) || (funct == FnMultu);
   assign is_div_fn = (funct == FnDiv) || (funct == FnDivu);
   assign launch    = (state_q == StIdle) && start && (is_mul_fn || is_div_fn);

   // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
      mul_step = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Restoring step: shift in the next dividend bit and keep the difference if it did not borrow.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_step;
   logic               unused_div_bit;

   always_comb begin
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
      div_ok    = ~div_diff[WIDTH+1];
      div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_step  = {div_rem, acc_q[WIDTH-2:0], div_ok};
   end

   // The kept difference is always below the divisor, so its top bit is never needed.
   assign unused_div_bit = div_diff[WIDTH];

`ifdef MULDIV_SIGNED_EN
   logic               sign_fn, neg_a, neg_b;
   logic               neg_res_q, neg_rem_q, is_div_q;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign sign_fn = (funct == FnMult) || (funct == FnDiv);
   assign neg_a   = sign_fn & srca[WIDTH-1];
   assign neg_b   = sign_fn & srcb[WIDTH-1];
   assign mag_a   = neg_a ? -srca : srca;
   assign mag_b   = neg_b ? -srcb : srcb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
      end else if (launch) begin
         neg_res_q <= neg_a ^ neg_b;
         neg_rem_q <= neg_a;
         is_div_q  <= is_div_fn;
      end
   end

   // Remainder follows the dividend's sign; quotient and product follow the sign product.
   always_comb begin
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
   end
`else
   assign mag_a  = srca;
   assign mag_b  = srcb;
   assign fix_hi = acc_q[2*WIDTH-1:WIDTH];
   assign fix_lo = acc_q[WIDTH-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               case (funct)
                  FnMthi: hi_d = srca;
                  FnMtlo: lo_d = srca;
                  FnMult, FnMultu: begin
                     acc_d   = {{WIDTH{1'b0}}, mag_a};
                     opb_d   = mag_b;
                     cnt_d   = '0;
                     state_d = StMul;
                  end
                  FnDiv, FnDivu: begin
                     acc_d   = {{WIDTH{1'b0}}, mag_a};
                     opb_d   = mag_b;
                     cnt_d   = '0;
                     state_d = StDiv;
                  end
                  default: ;
               endcase
            end
         end
         StMul: begin
            acc_d = mul_step;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StFix;
            end
         end
         StDiv: begin
            acc_d = div_step;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StFix;
            end
         end
         StFix: begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         opb_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opb_q  <= opb_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed vectors, corner sequences, random ops.
module tb_muldiv_hilo_unit;

   localparam logic [5:0] FnMthi  = 6'b010001;
   localparam logic [5:0] FnMtlo  = 6'b010011;
   localparam logic [5:0] FnMult  = 6'b011000;
   localparam logic [5:0] FnMultu = 6'b011001;
   localparam logic [5:0] FnDiv   = 6'b011010;
   localparam logic [5:0] FnDivu  = 6'b011011;
   localparam logic [5:0] FnAddu  = 6'b100001;

   logic        clk;
   logic        reset;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] srca, srcb;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   muldiv_hilo_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .funct (funct),
      .srca  (srca),
      .srcb  (srcb),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Architectural result {hi, lo} computed from plain arithmetic.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic sgn;
      longint p;
      int ai, bi;
`ifdef MULDIV_SIGNED_EN
      sgn = (f == FnMult) || (f == FnDiv);
`else
      sgn = 1'b0;
`endif
      if (f == FnMult || f == FnMultu) begin
         if (sgn) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
         end
         return {32'b0, a} * {32'b0, b};
      end
      if (b == 0) begin
         // magnitude quotient is all ones; negated when only the dividend is negative
         return {a, (sgn && a[31]) ? 32'h1 : 32'hffff_ffff};
      end
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'h0, 32'h8000_0000};
         ai = a;
         bi = b;
         return {32'(ai % bi), 32'(ai / bi)};
      end
      return {a % b, a / b};
   endfunction

   task automatic do_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int bc;
      @(negedge clk);
      start = 1'b1; funct = f; srca = a; srcb = b;
      @(negedge clk);
      start = 1'b0; funct = FnAddu; srca = $urandom; srcb = $urandom;
      bc = 0;
      while (busy === 1'b1 && bc < 100) begin
         bc++;
         if (bc == 16) check({nm, " hold_hilo"}, {hi, lo}, {m_hi, m_lo});
         @(negedge clk);
      end
      check({nm, " busy_cycles"}, bc, 33);
      check({nm, " done"}, done, 1);
      check({nm, " hi"}, hi, ehi);
      check({nm, " lo"}, lo, elo);
      m_hi = ehi; m_lo = elo;
      @(negedge clk);
      check({nm, " done_cleared"}, done, 0);
   endtask

   task automatic do_simple(input string nm, input logic [5:0] f, input logic [31:0] a);
      @(negedge clk);
      start = 1'b1; funct = f; srca = a; srcb = $urandom;
      if (f == FnMthi) m_hi = a;
      if (f == FnMtlo) m_lo = a;
      @(negedge clk);
      start = 1'b0;
      check({nm, " busy"}, busy, 0);
      check({nm, " done"}, done, 0);
      check({nm, " hilo"}, {hi, lo}, {m_hi, m_lo});
   endtask

   typedef struct {
      string       nm;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   vec_t vecs[8];
   logic [63:0] exp;
   logic [5:0] rf;
   logic [31:0] ra, rb;
   int sel, bsel, guard;

   initial begin
      vecs[0] = '{"multu_max", FnMultu, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h1};
`ifdef MULDIV_SIGNED_EN
      vecs[1] = '{"mult_neg", FnMult, 32'hffff_fffd, 32'd7, 32'hffff_ffff, 32'hffff_ffeb};
      vecs[2] = '{"div_neg", FnDiv, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd};
      vecs[5] = '{"div_ovf", FnDiv, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000};
      vecs[7] = '{"div_zero", FnDiv, 32'hffff_fff9, 32'h0, 32'hffff_fff9, 32'h1};
`else
      vecs[1] = '{"mult_neg", FnMult, 32'hffff_fffd, 32'd7, 32'h6, 32'hffff_ffeb};
      vecs[2] = '{"div_neg", FnDiv, 32'hffff_fff9, 32'd2, 32'h1, 32'h7fff_fffc};
      vecs[5] = '{"div_ovf", FnDiv, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'h0};
      vecs[7] = '{"div_zero", FnDiv, 32'hffff_fff9, 32'h0, 32'hffff_fff9, 32'hffff_ffff};
`endif
      vecs[3] = '{"divu_zero", FnDivu, 32'd100, 32'd0, 32'd100, 32'hffff_ffff};
      vecs[4] = '{"divu_7", FnDivu, 32'd100, 32'd7, 32'd2, 32'd14};
      vecs[6] = '{"multu_zero", FnMultu, 32'h1234_5678, 32'h0, 32'h0, 32'h0};

      reset = 1'b1; start = 1'b0; funct = '0; srca = '0; srcb = '0;
      repeat (2) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      reset = 1'b0;

      // MTHI then MTLO on consecutive cycles
      @(negedge clk);
      start = 1'b1; funct = FnMthi; srca = 32'h1234;
      @(negedge clk);
      funct = FnMtlo; srca = 32'h5678;
      check("mthi hi", hi, 32'h1234);
      check("mthi busy", busy, 0);
      @(negedge clk);
      start = 1'b0;
      check("mtlo lo", lo, 32'h5678);
      check("mtlo hi", hi, 32'h1234);
      check("mtlo busy", busy, 0);
      check("mtlo done", done, 0);
      m_hi = 32'h1234; m_lo = 32'h5678;

      do_simple("ignored_funct", FnAddu, 32'hdead_beef);

      foreach (vecs[i]) do_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].ehi,
                              vecs[i].elo);

      // Start while busy is ignored; a start in the done cycle is accepted.
      @(negedge clk);
      start = 1'b1; funct = FnMultu; srca = 32'hdead_beef; srcb = 32'h10;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; funct = FnDivu; srca = 32'd9; srcb = 32'd3;
      @(negedge clk);
      start = 1'b0;
      check("busy_start busy", busy, 1);
      check("busy_start hilo", {hi, lo}, {m_hi, m_lo});
      guard = 0;
      while (busy === 1'b1 && guard < 100) begin
         guard++;
         @(negedge clk);
      end
      check("busy_start done", done, 1);
      check("busy_start result", {hi, lo}, 64'h0000_000d_eadb_eef0);
      start = 1'b1; funct = FnMultu; srca = 32'd5; srcb = 32'd6;
      @(negedge clk);
      start = 1'b0;
      check("done_start busy", busy, 1);
      check("done_start done", done, 0);
      check("done_start hold", {hi, lo}, 64'h0000_000d_eadb_eef0);
      guard = 0;
      while (busy === 1'b1 && guard < 100) begin
         guard++;
         @(negedge clk);
      end
      check("done_start result", {done, hi, lo}, {1'b1, 64'd30});
      m_hi = 32'h0; m_lo = 32'd30;

      // Reset in the middle of a multiply
      do_simple("pre_reset_mthi", FnMthi, 32'hcafe_f00d);
      @(negedge clk);
      start = 1'b1; funct = FnMultu; srca = 32'h1357_9bdf; srcb = 32'h2468_ace0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("midreset busy_before", busy, 1);
      reset = 1'b1;
      #1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset hilo", {hi, lo}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      exp = model(FnMultu, 32'h1357_9bdf, 32'h2468_ace0);
      do_op("after_reset", FnMultu, 32'h1357_9bdf, 32'h2468_ace0, exp[63:32], exp[31:0]);

      for (int i = 0; i < 24; i++) begin
         sel  = $urandom_range(0, 7);
         bsel = $urandom_range(0, 4);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         case (bsel)
            0: rb = 32'h0;
            1: rb = $urandom_range(1, 15);
            2: rb = 32'hffff_ffff;
            default: ;
         endcase
         case (sel)
            0: rf = FnMult;
            1: rf = FnMultu;
            2: rf = FnDiv;
            3: rf = FnDivu;
            4: rf = FnMthi;
            5: rf = FnMtlo;
            6: rf = FnDiv;
            default: rf = FnAddu;
         endcase
         if (rf == FnMthi || rf == FnMtlo || rf == FnAddu) begin
            do_simple("rand_simple", rf, ra);
         end else begin
            exp = model(rf, ra, rb);
            do_op("rand_op", rf, ra, rb, exp[63:32], exp[31:0]);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage of the pipelined MIPS core.
- Consumes the R-type funct field and the spregwrite/mf controls produced by the main decoder.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO writes.
- Exports HI/LO for MFHI/MFLO and a busy flag that the hazard unit uses to stall the pipeline.

Parameters:
- WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous active-high reset
- start  input  1  EX-stage instruction is a valid muldiv/mthi/mtlo (spregwrite & ~stall)
- funct  input  6  R-type funct field
- srca  input  WIDTH  rs operand
- srcb  input  WIDTH  rt operand
- busy  output  1  multiply/divide in progress
- done  output  1  one-cycle pulse: HI/LO just updated by a MULT/DIV
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset asserted mid-operation aborts the operation; HI/LO still go to 0.
- funct decode:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - 010001 MTHI (hi<=srca), 010011 MTLO (lo<=srca).
  - Any other funct with start=1 is ignored.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start & MTHI/MTLO: the register is written at the next edge; no busy, no done; state stays IDLE.
  - start & MULT*/DIV*: capture operands at edge E, take magnitudes for signed ops, record result signs, counter=0, go to MUL or DIV.
- MUL: radix-2 shift-add, one bit per cycle. Holds a 2*WIDTH accumulator and the multiplier.
- DIV: restoring division, one quotient bit per cycle. Holds the remainder and the quotient.
- MUL/DIV exit to FIX when counter == WIDTH-1. Total iterations: WIDTH.
- FIX:
  - Apply the sign correction for signed ops.
  - Product: two's-complement negate of the 2*WIDTH value if the operand signs differ.
  - Quotient: negated if the signs differ. Remainder: takes the sign of the dividend.
  - At the edge leaving FIX (E+WIDTH+1):
    - MULT*: hi<=upper half, lo<=lower half.
    - DIV*: hi<=remainder, lo<=quotient.
  - done=1 for exactly one cycle; return to IDLE.
- busy = state in {MUL, DIV, FIX}. It is high in the cycles after edge E up to edge E+WIDTH+1 and is registered (no combinational path from start).
- start while busy is ignored. The hazard unit stalls mf, spregwrite and muldiv instructions while busy=1.
- done pulse and a new start in the same cycle: the new operation is accepted (state is IDLE).
- HI/LO hold their values throughout an operation until the final write. Reads during busy return the old values.
- Divide by zero:
  - The operation completes normally in the same latency.
  - DIVU result: lo=all ones, hi=dividend.
  - DIV result: the FIX correction applies to the magnitude result; no exception.
- DIV overflow (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0 (WIDTH=32).
- All arithmetic is WIDTH bits except the 2*WIDTH product accumulator; no saturation.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: MULT and DIV are signed as specified (magnitude conversion plus FIX correction).
- Undefined:
  - MULT decodes as MULTU and DIV decodes as DIVU.
  - The sign-handling logic is removed.
  - FIX still occupies one cycle, so latency is identical in both builds.

Test Plan:
- Reset mid-MULT (counter=10) -> busy=0, done=0, hi=0, lo=0 immediately; the next start runs cleanly.
- MULTU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> after WIDTH+1 edges done=1 for one cycle, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT (SIGNED_EN) srca=-3 (0xFFFFFFFD), srcb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without the macro -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV srca=-7, srcb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU srca=100, srcb=0 -> lo=0xFFFFFFFF, hi=100.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 one edge after each; busy and done stay 0.
- Second start issued while busy, then a start in the done cycle -> the first is ignored and HI/LO are unchanged until the original completes; the second is accepted, and busy rises on the next edge.
